// File: rtl/fifo_uart_tx.sv
// UART 8N1 transmitter that drains a byte FIFO: pops one byte whenever the FIFO
// is non-empty and shifts it out LSB first with one start and one stop bit.
module fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned CNT_W        = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_pop,
    output logic       tx,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    state_t           state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             bit_end;

    always_comb begin
        bit_end = (baud_cnt == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            tx       <= 1'b1;
            fifo_pop <= 1'b0;
            busy     <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx       <= 1'b1;
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    if (!fifo_empty) begin
                        state    <= FETCH;
                        fifo_pop <= 1'b1;
                        busy     <= 1'b1;
                    end else begin
                        fifo_pop <= 1'b0;
                        busy     <= 1'b0;
                    end
                end

                FETCH: begin
                    fifo_pop <= 1'b0;
                    state    <= LOAD;
                end

                // FIFO read data is valid from the edge that ended FETCH.
                LOAD: begin
                    shift    <= fifo_data;
                    tx       <= 1'b0;
                    baud_cnt <= '0;
                    state    <= START;
                end

                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= shift[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
                            tx      <= 1'b1;
                            state   <= STOP;
                        end else begin
                            shift   <= shift >> 1;
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end

                STOP: begin
                    tx <= 1'b1;
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        if (!fifo_empty) begin
                            state    <= FETCH;
                            fifo_pop <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state    <= IDLE;
                    tx       <= 1'b1;
                    fifo_pop <= 1'b0;
                    busy     <= 1'b0;
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Serial transmit stage that drains the byte FIFO sitting directly upstream.
- Pops one byte whenever the FIFO reports non-empty, then shifts it out as a UART 8N1 frame on a single line: start bit, 8 data bits LSB first, one stop bit.
- Sits between the FIFO output and the ECP5 TX pin; only sequential consumer of the FIFO read side.

Parameters:
- CLKS_PER_BIT, 104, clk cycles per serial bit (12 MHz / 115200); legal range ≥2.
- CNT_W, 16, width of the baud counter; must hold CLKS_PER_BIT-1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset), sampled on clk rising edge.
- fifo_empty  input  1  FIFO empty flag; 1 = no byte available.
- fifo_data  input  8  FIFO read data; valid on the clk rising edge after the cycle in which fifo_pop was 1.
- fifo_pop  output  1  registered one-cycle pop strobe to the FIFO.
- tx  output  1  serial line; idle high.
- busy  output  1  1 whenever state ≠ IDLE.

Behaviour:
- Reset (reset=0 at a rising edge):
  - state=IDLE, tx=1, fifo_pop=0, busy=0, baud counter=0, bit index=0, shift register=0x00.
  - Takes effect at that edge even mid-frame: tx is high from the next cycle and the in-flight byte is discarded.
  - No pop is issued while reset=0.
- States: IDLE, FETCH, LOAD, START, DATA, STOP. All outputs are registered.
- IDLE: tx=1. If fifo_empty=0 at the edge, go to FETCH and set fifo_pop=1.
- FETCH: fifo_pop=1 for exactly this one cycle. Next edge: fifo_pop=0, go to LOAD.
- LOAD: at the edge, capture fifo_data into the shift register, set tx=0, clear the baud counter, go to START.
- START: tx=0 for exactly CLKS_PER_BIT cycles. When counter=CLKS_PER_BIT-1: clear counter, set tx=shift[0], bit index=0, go to DATA.
- DATA: each bit is held CLKS_PER_BIT cycles. At bit end: shift right, increment bit index, drive the next bit. After bit index 7 ends: tx=1, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. At the end:
  - fifo_empty=0: go straight to FETCH with fifo_pop=1 (back-to-back).
  - otherwise: go to IDLE.
- Latency: fifo_empty falling, sampled in IDLE at edge E0 → fifo_pop high E0..E1 → tx falls at E2.
- Frame length: exactly 10*CLKS_PER_BIT cycles of start/data/stop.
- Back-to-back frames: the line stays high for CLKS_PER_BIT+2 cycles between data bit 7 and the next start bit (stop bit plus FETCH and LOAD).
- fifo_empty is ignored in FETCH, LOAD, START and DATA. At most one pop per frame; never pop while fifo_empty=1.
- Baud counter and bit index wrap to 0 at each bit/frame boundary; no free-running drift between frames.
- busy=1 from the edge entering FETCH through the last STOP cycle; busy=0 in IDLE.

Test Plan (CLKS_PER_BIT=4):
- Reset then idle, fifo_empty=1 for 50 cycles → tx=1, fifo_pop=0, busy=0 throughout.
- Single byte 0x55: fifo_empty falls, FIFO returns 0x55 after pop → exactly one 1-cycle pop. tx, 4 cycles each: 0,1,0,1,0,1,0,1,0,1; tx falls 2 cycles after pop asserts; busy returns to 0 after 40 cycles of frame.
- Two bytes 0xA3, 0x0F queued:
  - Frame 1 data bits are 1,1,0,0,0,1,0,1.
  - Line stays high 6 cycles (stop + FETCH + LOAD).
  - Frame 2 data bits are 1,1,1,1,0,0,0,0.
  - Exactly two pops; busy never drops between frames.
- Reset mid-frame: reset=0 during data bit 3 of 0xFF → tx=1 and busy=0 from the next cycle, no pop during reset. After release with fifo_empty=0, a fresh full frame starts (new pop, start bit 4 cycles).
- fifo_empty toggled during DATA (0→1→0) → no extra pop; frame bits unchanged; next pop only at end of stop bit.
- Sample tx at mid-bit with a reference UART receiver model over 256 random bytes → received bytes equal popped bytes, in order.
